// File: rtl/comp_pkg.sv
// comp_pkg: shared constants, table-entry type and FSM states for the compression hash lookup
package comp_pkg;
    localparam int HISTORY = 4096;
    localparam int PTR_W = 12;
    localparam logic [15:0] HASH_MULT = 16'd40543;
    typedef struct packed {
        logic valid;
        logic [PTR_W-1:0] pos;
    } entry_t;
    typedef enum logic {CLEAR, RUN} state_t;
endpackage

// File: rtl/comp_hash_lookup_if.sv
// comp_hash_lookup_if: key-in / offset-out bundle of the hash lookup
interface comp_hash_lookup_if #(parameter int PTR_W = comp_pkg::PTR_W);
    logic in_valid;
    logic in_ready;
    logic [23:0] to_hash;
    logic [PTR_W-1:0] byte_ptr;
    logic [PTR_W-1:0] offset;
    logic offset_valid;
    logic hit;
    logic [PTR_W-1:0] hash_idx;
    modport master(output in_valid, to_hash, byte_ptr, input in_ready, offset, offset_valid, hit, hash_idx);
    modport slave(input in_valid, to_hash, byte_ptr, output in_ready, offset, offset_valid, hit, hash_idx);
endinterface

// File: rtl/comp_hash_fn.sv
// comp_hash_fn: combinational 3-byte key -> table index hash
module comp_hash_fn #(parameter int PTR_W = comp_pkg::PTR_W) (
    input  logic [23:0]      key,
    output logic [PTR_W-1:0] idx
);
    import comp_pkg::*;
    logic [15:0] inner;
    logic [31:0] product;
    logic unused_product;
    assign inner = {key[23:16], 8'h00} ^ {4'h0, key[15:8], 4'h0} ^ {8'h00, key[7:0]};
    assign product = 32'(HASH_MULT) * 32'(inner);
    assign idx = product[PTR_W+3:4];
    assign unused_product = ^{product[31:PTR_W+4], product[3:0]};
endmodule

// File: rtl/comp_hash_lookup.sv
// comp_hash_lookup: hash a 3-byte key, return the previous position with the same index
// and record the current one; the table is swept invalid after every reset.
module comp_hash_lookup #(
    parameter int HISTORY = comp_pkg::HISTORY,
    parameter int PTR_W = comp_pkg::PTR_W
) (
    input logic clock,
    input logic reset,
    comp_hash_lookup_if.slave bus
);
    import comp_pkg::*;
    state_t state, state_nx;
    logic [PTR_W:0] clr_cnt, clr_cnt_nx;
    logic [PTR_W-1:0] key_idx, s1_idx, s1_ptr, wa, idx_q;
    logic s1_valid, we, ov;
    entry_t wd, rd_q;
    entry_t mem [HISTORY];

    comp_hash_fn #(.PTR_W(PTR_W)) u_hash (.key(bus.to_hash), .idx(key_idx));

    always_ff @(posedge clock)
        if (reset) begin
            state <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end

    always_comb begin
        state_nx = (state == CLEAR && clr_cnt == (PTR_W+1)'(HISTORY-1)) ? RUN : state;
        clr_cnt_nx = (state == CLEAR) ? clr_cnt + 1'b1 : clr_cnt;
    end

    assign bus.in_ready = state == RUN;

    always_ff @(posedge clock)
        if (reset) begin
            s1_valid <= 1'b0;
            s1_idx <= '0;
            s1_ptr <= '0;
        end else begin
            s1_valid <= bus.in_valid & bus.in_ready;
            s1_idx <= key_idx;
            s1_ptr <= bus.byte_ptr;
        end

    // Read and write share stage 2, so the next key always reads after the previous write landed
    always_comb begin
        we = (state == CLEAR) | s1_valid;
        wa = (state == CLEAR) ? clr_cnt[PTR_W-1:0] : s1_idx;
        wd.valid = state == RUN;
        wd.pos = (state == RUN) ? s1_ptr : '0;
    end

    always_ff @(posedge clock)
        if (we) mem[wa] <= wd;

    always_ff @(posedge clock)
        if (reset) begin
            rd_q <= '0;
            ov <= 1'b0;
            idx_q <= '0;
        end else begin
            ov <= s1_valid;
            if (s1_valid) begin
                rd_q <= mem[s1_idx];
                idx_q <= s1_idx;
            end
        end

    assign bus.offset_valid = ov;
    assign bus.hit = rd_q.valid;
    assign bus.offset = rd_q.valid ? rd_q.pos : '0;
    assign bus.hash_idx = idx_q;
endmodule

// File: doc/comp_hash_lookup.md
COMP_HASH_LOOKUP -- requirements
Module: comp_hash_lookup

Interface
REQ-001 SHALL have parameter HISTORY, default 4096, number of hash-table entries and history positions (power of two).
REQ-002 SHALL have parameter PTR_W, default 12, width of position/offset fields (log2 HISTORY).
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  to_hash/byte_ptr carry a new 3-byte key this cycle.
REQ-006 in_ready  output  1  block accepts a key; low while the table is being cleared.
REQ-007 to_hash  input  24  key bytes {p0,p1,p2}; p0 (oldest) in [23:16].
REQ-008 byte_ptr  input  PTR_W  history position of p0.
REQ-009 offset  output  PTR_W  previous position with same hash index; 0 on miss.
REQ-010 offset_valid  output  1  one-cycle pulse qualifying offset and hit.
REQ-011 hit  output  1  table entry was valid at lookup.
REQ-012 hash_idx  output  PTR_W  index computed for the key now on offset (debug/verification).

Function
REQ-013 SHALL accept a key only when in_valid and in_ready are both high (accept cycle).
REQ-014 SHALL compute inner = (p0<<8) ^ (p1<<4) ^ p2 as 16 bits, product = 40543*inner as 32 bits, index = product[15:4].
REQ-015 SHALL register index and byte_ptr in stage 1; stage 2 SHALL read the entry at index and write {valid=1, pos=byte_ptr} into it in the same cycle.
REQ-016 SHALL assert offset_valid exactly 2 cycles after an accept cycle, once per accepted key, with back-to-back throughput of one key per cycle.
REQ-017 Entry valid: offset = stored pos, hit = 1. Entry invalid: offset = 0, hit = 0.
REQ-018 Read-during-write to the same entry in stage 2 SHALL return the old contents.
REQ-019 Consecutive keys with the same index SHALL see the immediately preceding write (forwarding from stage 2 write to next read); no stale reads.
REQ-020 When offset_valid is low, offset, hit and hash_idx SHALL hold their last values.
REQ-021 FSM states: CLEAR, RUN. CLEAR: clear-address counter walks 0..HISTORY-1, one entry invalidated per cycle, in_ready = 0. Counter = HISTORY-1 -> RUN on the next cycle. RUN: in_ready = 1; no exit except reset.
REQ-022 in_valid during CLEAR SHALL be ignored; no table write, no offset_valid.
REQ-023 Clear counter SHALL be PTR_W+1 bits wide; no wrap before the transition to RUN.

Reset
REQ-024 reset high SHALL, on the next edge, enter CLEAR with clear address 0, flush both pipeline stages and zero offset, offset_valid, hit and hash_idx.
REQ-025 Reset asserted mid-operation or mid-CLEAR SHALL discard in-flight keys (no offset_valid) and restart the full sweep.
REQ-026 in_ready SHALL be low from the first edge with reset high until HISTORY cycles after reset deasserts.

Structure
REQ-027 Shared package comp_pkg SHALL hold HISTORY, PTR_W, the hash multiplier 40543 and the table-entry struct {valid, pos}.
REQ-028 Hash arithmetic SHALL be a sub-module comp_hash_fn (combinational key -> index); table storage SHALL be an inferred single-clock RAM with synchronous read.

Verification
REQ-029 Reset, then wait: in_ready low exactly 4096 cycles after reset falls, then high.
REQ-030 Key 0x616263, byte_ptr 5 -> 2 cycles later offset_valid=1, hash_idx=0xABD, hit=0, offset=0.
REQ-031 Same key 0x616263, byte_ptr 20, next cycle (back-to-back) -> hit=1, offset=5 (forwarding); third key at byte_ptr 40 -> offset=20.
REQ-032 Two keys with different indices back-to-back -> two consecutive offset_valid pulses, each hit=0; neither entry corrupted on revisit.
REQ-033 Reset pulsed with keys in flight -> no offset_valid afterwards; after the new sweep, key 0x616263 -> hit=0.
REQ-034 in_valid held high during CLEAR -> no offset_valid and no entries written; first RUN lookup -> hit=0.
